// File: rtl/sim_uart_pkg.sv
// Shared types and helpers for the simulation-side UART blocks.
//   uart_rx_state_e : receive state machine encoding (also exported for debug)
//   PAR_*           : parity mode codes used by the PARITY parameter
//   parity_ok()     : checks a received parity bit against a data byte
package sim_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_rx_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // True when data plus par_bit carry the parity the mode asks for.
   // With no parity configured every bit is acceptable.
   function automatic logic parity_ok(input logic [7:0] data,
                                      input logic       par_bit,
                                      input int         mode);
      logic ones_odd;
      ones_odd = (^data) ^ par_bit;
      case (mode)
         PAR_ODD:  return ones_odd;
         PAR_EVEN: return ~ones_odd;
         default:  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/sim_uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   theclk    : destination clock
//   theresetn : asynchronous active-low reset, both flops load RSTVAL
//   d         : asynchronous input level
//   q         : synchronized level, two theclk cycles behind d
module sim_uart_sync2 #(
   parameter logic RSTVAL = 1'b1
) (
   input  logic theclk,
   input  logic theresetn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge theclk or negedge theresetn) begin
      if (!theresetn) begin
         meta <= RSTVAL;
         q    <= RSTVAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sim_uart_rx_deframer.sv
// Simulation-side UART receiver. Samples the SoC serial line at mid-bit and
// emits one-cycle byte strobes for the line-printing monitor.
//   theclk          : sampling clock
//   theresetn       : asynchronous active-low reset
//   serial_in       : asynchronous UART line, idle high
//   uart_data       : last accepted byte, held until the next one
//   uart_data_valid : one-cycle strobe, uart_data is good this cycle
//   frame_err       : one-cycle strobe, a stop bit sampled low (byte dropped)
//   parity_err      : one-cycle strobe alongside valid on parity mismatch
//   busy            : high whenever the receiver is not idle
//   dbg_state       : current receive state
//
// Handshake: uart_data_valid is a pure strobe with no ready. The consumer
// must take uart_data on the cycle valid is high; nothing stalls or queues.
module sim_uart_rx_deframer
   import sim_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic           theclk,
   input  logic           theresetn,
   input  logic           serial_in,
   output logic [7:0]     uart_data,
   output logic           uart_data_valid,
   output logic           frame_err,
   output logic           parity_err,
   output logic           busy,
   output uart_rx_state_e dbg_state
);

   localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

   logic rx_s;

   sim_uart_sync2 #(.RSTVAL(1'b1)) u_sync (
      .theclk    (theclk),
      .theresetn (theresetn),
      .d         (serial_in),
      .q         (rx_s)
   );

   uart_rx_state_e   state,    state_nxt;
   logic [CNT_W-1:0] bitcnt,   bitcnt_nxt;
   logic [3:0]       bitidx,   bitidx_nxt;
   logic [7:0]       shreg,    shreg_nxt;
   logic             par_pend, par_pend_nxt;
   logic [7:0]       data_nxt;
   logic             valid_nxt, ferr_nxt, perr_nxt;
   logic             bit_tick;

   // bitcnt reaching zero marks the sampling point of the current bit.
   assign bit_tick = (bitcnt == '0);

   always_comb begin
      state_nxt    = state;
      bitcnt_nxt   = bit_tick ? bitcnt : bitcnt - CNT_W'(1);
      bitidx_nxt   = bitidx;
      shreg_nxt    = shreg;
      par_pend_nxt = par_pend;
      data_nxt     = uart_data;
      valid_nxt    = 1'b0;
      ferr_nxt     = 1'b0;
      perr_nxt     = 1'b0;

      case (state)
         ST_IDLE: begin
            // First low level: wait half a bit to land in the start bit centre.
            if (!rx_s) begin
               bitcnt_nxt = HALF_LOAD;
               state_nxt  = ST_START;
            end
         end

         ST_START: begin
            if (bit_tick) begin
               if (!rx_s) begin
                  bitcnt_nxt   = FULL_LOAD;
                  bitidx_nxt   = 4'd0;
                  par_pend_nxt = 1'b0;
                  state_nxt    = ST_DATA;
               end else begin
                  // Line was back high at mid-start: treat as a glitch.
                  state_nxt = ST_IDLE;
               end
            end
         end

         ST_DATA: begin
            if (bit_tick) begin
               shreg_nxt  = {rx_s, shreg[7:1]};
               bitcnt_nxt = FULL_LOAD;
               if (bitidx == 4'd7) begin
                  bitidx_nxt = 4'd0;
                  state_nxt  = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bitidx_nxt = bitidx + 4'd1;
               end
            end
         end

         ST_PARITY: begin
            if (bit_tick) begin
               // Mismatch is only remembered here; it is reported with the byte.
               par_pend_nxt = ~parity_ok(shreg, rx_s, PARITY);
               bitcnt_nxt   = FULL_LOAD;
               state_nxt    = ST_STOP;
            end
         end

         ST_STOP: begin
            if (bit_tick) begin
               if (!rx_s) begin
                  ferr_nxt  = 1'b1;
                  state_nxt = ST_BREAK;
               end else if (bitidx == STOP_LAST) begin
                  // Leaving at mid-stop lets a start edge half a bit later be caught.
                  valid_nxt = 1'b1;
                  data_nxt  = shreg;
                  perr_nxt  = par_pend;
                  state_nxt = ST_IDLE;
               end else begin
                  bitidx_nxt = bitidx + 4'd1;
                  bitcnt_nxt = FULL_LOAD;
               end
            end
         end

         ST_BREAK: begin
            // A line held low must return high before a new start is armed.
            if (rx_s) begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge theclk or negedge theresetn) begin
      if (!theresetn) begin
         state           <= ST_IDLE;
         bitcnt          <= '0;
         bitidx          <= 4'd0;
         shreg           <= 8'd0;
         par_pend        <= 1'b0;
         uart_data       <= 8'd0;
         uart_data_valid <= 1'b0;
         frame_err       <= 1'b0;
         parity_err      <= 1'b0;
      end else begin
         state           <= state_nxt;
         bitcnt          <= bitcnt_nxt;
         bitidx          <= bitidx_nxt;
         shreg           <= shreg_nxt;
         par_pend        <= par_pend_nxt;
         uart_data       <= data_nxt;
         uart_data_valid <= valid_nxt;
         frame_err       <= ferr_nxt;
         parity_err      <= perr_nxt;
      end
   end

   assign busy      = (state != ST_IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_sim_uart_rx_deframer.sv
// Bench for sim_uart_rx_deframer. Two receivers share clock and reset:
//   u_dut0 : 8N1            driven from ser0
//   u_dut1 : 8E2 (even, 2 stop bits) driven from ser1
// The frame driver predicts each receiver's outcome (byte, strobes and the
// cycle they appear) from the frame's bit levels and queues it; the negedge
// compare process checks every cycle against those queues.
module tb_sim_uart_rx_deframer;
   import sim_uart_pkg::*;

   localparam int CPB = 16;

   logic theclk    = 1'b0;
   logic theresetn = 1'b0;
   logic ser0      = 1'b1;
   logic ser1      = 1'b1;

   logic [7:0]     d0, d1;
   logic           v0, v1, fe0, fe1, pe0, pe1, b0, b1;
   uart_rx_state_e st0, st1;

   sim_uart_rx_deframer #(.CLKS_PER_BIT(CPB), .PARITY(PAR_NONE), .STOP_BITS(1)) u_dut0 (
      .theclk          (theclk),
      .theresetn       (theresetn),
      .serial_in       (ser0),
      .uart_data       (d0),
      .uart_data_valid (v0),
      .frame_err       (fe0),
      .parity_err      (pe0),
      .busy            (b0),
      .dbg_state       (st0)
   );

   sim_uart_rx_deframer #(.CLKS_PER_BIT(CPB), .PARITY(PAR_EVEN), .STOP_BITS(2)) u_dut1 (
      .theclk          (theclk),
      .theresetn       (theresetn),
      .serial_in       (ser1),
      .uart_data       (d1),
      .uart_data_valid (v1),
      .frame_err       (fe1),
      .parity_err      (pe1),
      .busy            (b1),
      .dbg_state       (st1)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 theclk = ~theclk;

   int unsigned cyc = 0;
   always @(posedge theclk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_bad = 0;

   // Event word: {cycle[31:0], data[7:0], valid, parity_err, frame_err}
   logic [42:0] exp_q0[$];
   logic [42:0] exp_q1[$];

   int          par_mode[2]  = '{PAR_NONE, PAR_EVEN};
   int          stops[2]     = '{1, 2};
   logic [7:0]  last_data[2] = '{8'h00, 8'h00};
   int unsigned last_vcyc[2] = '{0, 0};
   int          v_cnt[2]     = '{0, 0};
   int          pe_cnt[2]    = '{0, 0};
   int          fe_cnt[2]    = '{0, 0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int id, input logic [42:0] ev);
      if (id == 0) exp_q0.push_back(ev);
      else         exp_q1.push_back(ev);
   endtask

   // ---------------- compare process ----------------
   task automatic compare(input int id, input logic [7:0] d, input logic v,
                          input logic p, input logic f);
      logic [42:0] e;
      logic        have;
      e    = '0;
      have = (id == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
      if (have) e = (id == 0) ? exp_q0[0] : exp_q1[0];
      if (have && (e[42:11] < cyc)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL missed_strobe%0d: got none expected vpf=%0b at cycle %0d",
                  id, e[2:0], e[42:11]);
         if (id == 0) void'(exp_q0.pop_front());
         else         void'(exp_q1.pop_front());
         have = 1'b0;
      end
      if (v) begin
         v_cnt[id]++;
         last_vcyc[id] = cyc;
      end
      if (p) pe_cnt[id]++;
      if (f) fe_cnt[id]++;
      if (v || p || f) begin
         if (!have || (e[42:11] != cyc)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe%0d: got vpf=%0b expected none", id, {v, p, f});
         end else begin
            check($sformatf("strobes%0d", id), {29'd0, v, p, f}, {29'd0, e[2:0]});
            if (e[2]) last_data[id] = e[10:3];
            if (id == 0) void'(exp_q0.pop_front());
            else         void'(exp_q1.pop_front());
         end
      end
      check($sformatf("uart_data%0d", id), {24'd0, d}, {24'd0, last_data[id]});
   endtask

   always @(negedge theclk) begin
      compare(0, d0, v0, pe0, fe0);
      compare(1, d1, v1, pe1, fe1);
   end

   // ---------------- driver tasks ----------------
   // All driver tasks start and end at posedge + #1.
   task automatic idle(input int n);
      repeat (n) @(posedge theclk);
      #1;
   endtask

   task automatic set_line(input int id, input logic lv);
      if (id == 0) ser0 = lv;
      else         ser1 = lv;
   endtask

   // Sends one frame and queues the predicted outcome. stop_lv[s] is the
   // level of stop bit s. If the last stop bit is low the line is held low
   // for hold_low more cycles, then released high.
   task automatic send_frame(input int id, input logic [7:0] b, input logic par_bit,
                             input logic [1:0] stop_lv, input int hold_low,
                             output int unsigned k);
      logic        lv[12];
      int          np, ns, nbits, n_ev, ones;
      logic        ferr, perr;
      logic [31:0] ev_cyc;
      np = (par_mode[id] != PAR_NONE) ? 1 : 0;
      ns = stops[id];
      lv[0] = 1'b0;
      for (int i = 0; i < 8; i++) lv[1 + i] = b[i];
      if (np == 1) lv[9] = par_bit;
      for (int s = 0; s < ns; s++) lv[9 + np + s] = stop_lv[s];
      nbits = 9 + np + ns;
      // Outcome: the first low stop bit is a frame error, else the byte lands
      // at the last stop bit. Strobe appears 3 cycles (2 sync + register)
      // after the half-bit point of the deciding bit.
      ferr = 1'b0;
      n_ev = nbits - 1;
      for (int s = ns - 1; s >= 0; s--) begin
         if (!stop_lv[s]) begin
            ferr = 1'b1;
            n_ev = 9 + np + s;
         end
      end
      ones = $countones(b) + int'(par_bit);
      perr = (np == 1) && ((ones % 2) != ((par_mode[id] == PAR_ODD) ? 1 : 0));
      k = cyc;
      ev_cyc = k + 3 + CPB / 2 + CPB * n_ev;
      push_ev(id, {ev_cyc, b, ~ferr, (~ferr) & perr, ferr});
      for (int i = 0; i < nbits; i++) begin
         set_line(id, lv[i]);
         idle(CPB);
      end
      if (ferr) begin
         if (!lv[nbits - 1] && (hold_low > 0)) begin
            idle(hold_low);
            check($sformatf("break_busy%0d", id), {31'd0, (id == 0) ? b0 : b1}, 32'd1);
            check($sformatf("break_state%0d", id),
                  {29'd0, (id == 0) ? st0 : st1}, {29'd0, ST_BREAK});
         end
         set_line(id, 1'b1);
         idle(2);
      end
   endtask

   // ---------------- stimulus ----------------
   int unsigned k;
   int          vc;
   logic [7:0]  rb;
   logic        rp;
   logic [1:0]  rs;
   int          rid;

   initial begin
      theresetn = 1'b0;
      idle(3);
      theresetn = 1'b1;
      idle(4);

      // Reset state
      check("rst_busy0",  {31'd0, b0}, 32'd0);
      check("rst_busy1",  {31'd0, b1}, 32'd0);
      check("rst_valid0", {31'd0, v0}, 32'd0);
      check("rst_data0",  {24'd0, d0}, 32'd0);
      check("rst_state0", {29'd0, st0}, {29'd0, ST_IDLE});

      // 8N1 0x55: latency from start edge is 9.5 bits + 3 = 155 cycles
      send_frame(0, 8'h55, 1'b0, 2'b11, 0, k);
      idle(20);
      check("lat_55",   last_vcyc[0] - k, 32'd155);
      check("data_55",  {24'd0, d0}, 32'h55);
      check("idle_55",  {31'd0, b0}, 32'd0);
      check("vcnt_55",  v_cnt[0], 32'd1);

      // 6-cycle start glitch: no strobe, data held
      vc = v_cnt[0];
      ser0 = 1'b0;
      idle(6);
      ser0 = 1'b1;
      idle(2 * CPB);
      check("glitch_vcnt", v_cnt[0], vc);
      check("glitch_data", {24'd0, d0}, 32'h55);
      check("glitch_busy", {31'd0, b0}, 32'd0);

      // 0xA3 with low stop bit held low, then 0x0D
      send_frame(0, 8'hA3, 1'b0, 2'b00, 40, k);
      idle(5);
      check("ferr_cnt",  fe_cnt[0], 32'd1);
      check("ferr_data", {24'd0, d0}, 32'h55);
      send_frame(0, 8'h0D, 1'b0, 2'b11, 0, k);
      idle(10);
      check("after_break", {24'd0, d0}, 32'h0D);

      // 8E2: 0x07 with wrong parity bit 0, then correct bit 1
      send_frame(1, 8'h07, 1'b0, 2'b11, 0, k);
      idle(10);
      check("perr_bad",  pe_cnt[1], 32'd1);
      check("perr_data", {24'd0, d1}, 32'h07);
      send_frame(1, 8'h07, 1'b1, 2'b11, 0, k);
      idle(10);
      check("perr_good", pe_cnt[1], 32'd1);
      check("perr_vcnt", v_cnt[1], 32'd2);

      // "OK\n" back-to-back
      vc = v_cnt[0];
      send_frame(0, 8'h4F, 1'b0, 2'b11, 0, k);
      send_frame(0, 8'h4B, 1'b0, 2'b11, 0, k);
      send_frame(0, 8'h0A, 1'b0, 2'b11, 0, k);
      idle(10);
      check("ok_vcnt", v_cnt[0] - vc, 32'd3);
      check("ok_last", {24'd0, d0}, 32'h0A);

      // Reset during bit 4 of 0xFF, then 0x31
      vc = v_cnt[0];
      ser0 = 1'b0;
      idle(CPB);
      ser0 = 1'b1;
      idle(4 * CPB + 5);
      theresetn    = 1'b0;
      last_data[0] = 8'h00;
      last_data[1] = 8'h00;
      #1;
      check("midrst_busy", {31'd0, b0}, 32'd0);
      check("midrst_data", {24'd0, d0}, 32'd0);
      idle(3);
      theresetn = 1'b1;
      idle(20);
      send_frame(0, 8'h31, 1'b0, 2'b11, 0, k);
      idle(10);
      check("midrst_vcnt", v_cnt[0] - vc, 32'd1);
      check("midrst_next", {24'd0, d0}, 32'h31);

      // Randomized frames on both receivers
      for (int i = 0; i < 40; i++) begin
         rid = $urandom_range(0, 1);
         rb  = 8'($urandom);
         rp  = (^rb) ^ ($urandom_range(0, 3) == 0);
         rs  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         send_frame(rid, rb, rp, rs, $urandom_range(0, 30), k);
         idle($urandom_range(0, 12));
      end

      idle(200);
      check("drain_q0", exp_q0.size(), 32'd0);
      check("drain_q1", exp_q1.size(), 32'd0);
      check("end_busy0", {31'd0, b0}, 32'd0);
      check("end_busy1", {31'd0, b1}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
